// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 Gaussian convolution engine: kernel taps,
// normalisation shift, rounding constant and the output status codes.
package conv_pkg;

    localparam int unsigned KERNEL [0:2][0:2] = '{
        '{32'd1, 32'd2, 32'd1},
        '{32'd2, 32'd4, 32'd2},
        '{32'd1, 32'd2, 32'd1}
    };

    localparam int unsigned NORM_SHIFT  = 32'd4;
    localparam int unsigned ROUND_CONST = 32'd8;

    typedef enum logic [1:0] {
        PRIME = 2'b00,
        VALID = 2'b01,
        EDGE  = 2'b10
    } valid_e;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: delayed_out is the pixel shifted in DEPTH samples ago.
// Circular RAM with read-before-write; contents are not cleared by rst.
module line_buffer #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 540
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] shift_in,
    output logic [WORD_SIZE-1:0] delayed_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_SIZE-1:0] mem_q [0:DEPTH-1];
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;

    // Next write/read pointer, wrapping at DEPTH.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_q == PTR_W'(DEPTH - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage; no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[ptr_q] <= shift_in;
        end
    end

    assign delayed_out = mem_q[ptr_q];

endmodule

// File: rtl/convolution.sv
// Streaming 3x3 Gaussian convolution, one pixel in and one result out per clock.
// Define CONVOLUTION_ROUND_EN for round-half-up normalisation (default truncates).
module convolution
    import conv_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 540
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] inputPixel,
    output logic [WORD_SIZE-1:0] outputPixel,
    output logic [1:0]           valid
);

    localparam int COL_W = $clog2(ROW_SIZE);
    localparam int SUM_W = WORD_SIZE + 4;
`ifdef CONVOLUTION_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic [WORD_SIZE-1:0] tap1_s;
    logic [WORD_SIZE-1:0] tap2_s;

    logic [COL_W-1:0]     col_q, col_d;
    logic [1:0]           row_q, row_d;
    logic [WORD_SIZE-1:0] win_q [0:2][0:2];
    logic [WORD_SIZE-1:0] win_d [0:2][0:2];
    valid_e               stat_q, stat_d;
    logic [WORD_SIZE-1:0] out_q, out_d;
    valid_e               valid_q, valid_d;
    logic [SUM_W-1:0]     sum_s;
    logic [SUM_W-1:0]     rnd_sum_s;

    line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb1 (
        .clk        (clk),
        .rst        (rst),
        .shift_in   (inputPixel),
        .delayed_out(tap1_s)
    );

    line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb2 (
        .clk        (clk),
        .rst        (rst),
        .shift_in   (tap1_s),
        .delayed_out(tap2_s)
    );

    // Position tracking, window shift and status of the pixel being sampled.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (col_q == COL_W'(ROW_SIZE - 1)) begin
            col_d = '0;
            if (row_q != 2'd2) begin
                row_d = row_q + 2'd1;
            end else begin
                row_d = row_q;
            end
        end else begin
            col_d = col_q + COL_W'(1);
        end

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
        end
        // Oldest row on index 0, live input on index 2.
        win_d[0][2] = tap2_s;
        win_d[1][2] = tap1_s;
        win_d[2][2] = inputPixel;

        if (row_q < 2'd2) begin
            stat_d = PRIME;
        end else if (col_q < COL_W'(2)) begin
            stat_d = EDGE;
        end else begin
            stat_d = VALID;
        end
    end

    // Kernel sum over the current window and normalisation.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum_s = sum_s + SUM_W'(win_q[i][j]) * SUM_W'(KERNEL[i][j]);
            end
        end
        rnd_sum_s = sum_s + (ROUND_EN ? SUM_W'(ROUND_CONST) : SUM_W'(0));
        out_d     = WORD_SIZE'(rnd_sum_s >> NORM_SHIFT);
        valid_d   = stat_q;
    end

    // Pipeline registers: sample stage then output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= 2'd0;
            win_q   <= '{default: '0};
            stat_q  <= PRIME;
            out_q   <= '0;
            valid_q <= PRIME;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            stat_q  <= stat_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign outputPixel = out_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_convolution.sv
// Scoreboard bench for convolution with ROW_SIZE=8; expectations come from a
// reference image model of every pixel sampled since the last reset.
module tb_convolution;

    localparam int W = 8;
    localparam int R = 8;
    localparam int K [0:2][0:2] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

    typedef struct {
        logic [W-1:0] px;
        logic [1:0]   st;
        bit           chk_px;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] inputPixel = '0;
    logic [W-1:0] outputPixel;
    logic [1:0]   valid;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   img [0:15][0:R-1];
    int   mrow = 0;
    int   mcol = 0;
    int   obs01 = 0;

    convolution #(.WORD_SIZE(W), .ROW_SIZE(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .inputPixel (inputPixel),
        .outputPixel(outputPixel),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the following negedge.
    task automatic drive_px(input string tag, input logic [W-1:0] p);
        exp_t e;
        int   s;
        inputPixel = p;
        @(posedge clk);
        img[mrow][mcol] = p;
        e.px     = '0;
        e.chk_px = 1'b0;
        if (mrow < 2) begin
            e.st = 2'b00;
        end else if (mcol < 2) begin
            e.st = 2'b10;
        end else begin
            e.st     = 2'b01;
            e.chk_px = 1'b1;
            s = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    s += K[i][j] * img[mrow-2+i][mcol-2+j];
`ifdef CONVOLUTION_ROUND_EN
            s += 8;
`endif
            e.px = W'(s >> 4);
        end
        sb.push_back(e);
        if (mcol == R - 1) begin
            mcol = 0;
            if (mrow < 15) mrow++;
        end else begin
            mcol++;
        end
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check({tag, "_status"}, 32'(valid), 32'(e.st));
            if (valid == 2'b01) obs01++;
            if (e.chk_px) check({tag, "_pixel"}, 32'(outputPixel), 32'(e.px));
        end
    endtask

    // Called on a negedge: one reset cycle, then outputs must read 0/00.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        inputPixel = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rst_pixel"}, 32'(outputPixel), 32'd0);
        check({tag, "_rst_valid"}, 32'(valid), 32'd0);
        rst = 1'b0;
        sb.delete();
        mrow  = 0;
        mcol  = 0;
        obs01 = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset("init");

        for (int r = 0; r < 6; r++)
            for (int c = 0; c < R; c++)
                drive_px("const", 8'h64);
        drive_px("const", 8'h00);
        check("const_valid_count", 32'(obs01), 32'd24);

        do_reset("impulse");
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < R; c++)
                drive_px("impulse", (r == 3 && c == 3) ? 8'hFF : 8'h00);
        drive_px("impulse", 8'h00);
        check("impulse_valid_count", 32'(obs01), 32'd30);

        do_reset("ramp");
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < R; c++)
                drive_px("ramp", W'(c * 16));
        drive_px("ramp", 8'h00);

        do_reset("ones");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < R; c++)
                drive_px("ones", 8'hFF);
        drive_px("ones", 8'hFF);

        do_reset("rand");
        for (int k = 0; k < 4 * R + 3; k++)
            drive_px("rand", W'($urandom_range(255, 0)));
        do_reset("midrst");
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < R; c++)
                drive_px("midrst", W'($urandom_range(255, 0)));
        drive_px("midrst", 8'h00);
        check("midrst_valid_count", 32'(obs01), 32'd18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
